// File: rtl/alu_seq_pkg.sv
// Shared opcodes, ALU selects, instruction field positions and FSM states
// for the ALU sequencer.
package alu_seq_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam int OPC_LO  = 24;
  localparam int DST_LO  = 16;
  localparam int SRC1_LO = 8;
  localparam int SRC2_LO = 0;
  localparam int REG_W   = 3;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode decoder: ALU select, immediate/negate operand
// controls, wait-class select and illegal flag.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [2:0] aluop,
  output logic       use_imm,
  output logic       negate,
  output logic       wait_sel,
  output logic       illegal
);

  always_comb begin
    aluop    = ALU_FWD;
    use_imm  = 1'b0;
    negate   = 1'b0;
    wait_sel = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_LOADI: use_imm = 1'b1;
      OP_MOV:   ;
      OP_ADD: begin
        aluop    = ALU_ADD;
        wait_sel = 1'b1;
      end
      OP_SUB: begin
        aluop    = ALU_ADD;
        negate   = 1'b1;
        wait_sel = 1'b1;
      end
      OP_AND:   aluop = ALU_AND;
      OP_OR:    aluop = ALU_OR;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer driving the 8-bit ALU and register file for one
// instruction at a time. Optional retire counter: ALUSEQ_RETIRE_CNT_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned ADD_WAIT   = 2,
  parameter int unsigned LOGIC_WAIT = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  output logic [2:0]  READREG1,
  output logic [2:0]  READREG2,
  input  logic [7:0]  REGOUT1,
  input  logic [7:0]  REGOUT2,
  output logic [7:0]  OPERAND1,
  output logic [7:0]  OPERAND2,
  output logic [2:0]  ALUOP,
  output logic [2:0]  WRITEREG,
  output logic        WRITEENABLE,
  output logic        BUSY,
  output logic        ILLEGAL
`ifdef ALUSEQ_RETIRE_CNT_EN
  ,
  output logic [15:0] RETIRED
`endif
);

  state_t     state, next_state;
  logic [3:0] cnt;
  logic       accept;

  logic [2:0] dec_aluop;
  logic       dec_use_imm, dec_negate, dec_wait_sel, dec_illegal;

  logic [7:0] imm_q;
  logic [2:0] aluop_q;
  logic       use_imm_q, negate_q, wait_sel_q;

  logic       unused_instr_bits;
  assign unused_instr_bits = ^{INSTR[DST_LO+REG_W +: 5], INSTR[SRC1_LO+REG_W +: 5]};

  // Decoding the incoming word lets an illegal opcode be rejected at the
  // accept edge without ever leaving IDLE.
  alu_seq_decode u_decode (
    .opcode   (INSTR[OPC_LO +: 8]),
    .aluop    (dec_aluop),
    .use_imm  (dec_use_imm),
    .negate   (dec_negate),
    .wait_sel (dec_wait_sel),
    .illegal  (dec_illegal)
  );

  assign accept = INSTR_VALID && INSTR_READY;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && !dec_illegal) next_state = READ;
      READ:    next_state = EXEC;
      EXEC:    if (cnt <= 4'd1) next_state = WB;
      WB:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    INSTR_READY = (state == IDLE) && !RESET;
    BUSY        = (state != IDLE);
    WRITEENABLE = (state == WB);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      READREG1   <= '0;
      READREG2   <= '0;
      WRITEREG   <= '0;
      OPERAND1   <= '0;
      OPERAND2   <= '0;
      ALUOP      <= ALU_FWD;
      ILLEGAL    <= 1'b0;
      cnt        <= '0;
      imm_q      <= '0;
      aluop_q    <= ALU_FWD;
      use_imm_q  <= 1'b0;
      negate_q   <= 1'b0;
      wait_sel_q <= 1'b0;
    end else begin
      ILLEGAL <= accept && dec_illegal;
      if (accept && !dec_illegal) begin
        READREG1   <= INSTR[SRC1_LO +: REG_W];
        READREG2   <= INSTR[SRC2_LO +: REG_W];
        WRITEREG   <= INSTR[DST_LO +: REG_W];
        imm_q      <= INSTR[SRC2_LO +: 8];
        aluop_q    <= dec_aluop;
        use_imm_q  <= dec_use_imm;
        negate_q   <= dec_negate;
        wait_sel_q <= dec_wait_sel;
      end
      if (state == READ) begin
        OPERAND1 <= REGOUT1;
        if (use_imm_q)     OPERAND2 <= imm_q;
        else if (negate_q) OPERAND2 <= ~REGOUT2 + 8'd1;
        else               OPERAND2 <= REGOUT2;
        ALUOP <= aluop_q;
        cnt   <= wait_sel_q ? 4'(ADD_WAIT) : 4'(LOGIC_WAIT);
      end else if (state == EXEC) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

`ifdef ALUSEQ_RETIRE_CNT_EN
  always_ff @(posedge CLK) begin
    if (RESET)                           RETIRED <= '0;
    else if (WRITEENABLE && RETIRED != '1) RETIRED <= RETIRED + 16'd1;
  end
`endif

endmodule
